// File: rtl/gates_sweep_checker.sv
// Self-test sweep for the 2-input gate bank: applies vectors 00..11, lets each settle,
// checks y against the truth table. Optional build macro: GATE_CHK_STOP_ON_ERR_EN.
module gates_sweep_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] y_in,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [6:0] err_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [6:0] err_mask_q, err_mask_d;

    logic [6:0] diff;
    logic       mismatch;
    logic       stop_now;
    logic       last_vec;
    logic [2:0] err_cnt_inc;

    // Bit order matches the gate bank: [6]NOT a [5]XNOR [4]XOR [3]NOR [2]NAND [1]OR [0]AND
    function automatic logic [6:0] expected_y(input logic a_v, input logic b_v);
        return {~a_v, ~(a_v ^ b_v), a_v ^ b_v, ~(a_v | b_v), ~(a_v & b_v), a_v | b_v, a_v & b_v};
    endfunction

    assign diff        = y_in ^ expected_y(vec_q[1], vec_q[0]);
    assign mismatch    = |diff;
    assign last_vec    = (vec_q == 2'd3);
    assign err_cnt_inc = err_cnt_q + 3'(mismatch);

`ifdef GATE_CHK_STOP_ON_ERR_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = SETTLE;
            SETTLE:     if (cnt_q == 8'd0) state_d = CHECK;
            CHECK:      state_d = (last_vec || stop_now) ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d      = SETTLE_LOAD;
                    vec_d      = 2'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    err_mask_d = '0;
                end
            end
            SETTLE: begin
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            end
            CHECK: begin
                err_cnt_d  = err_cnt_inc;
                err_mask_d = err_mask_q | diff;
                if (last_vec || stop_now) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_cnt_inc == 3'd0);
                end else begin
                    vec_d = vec_q + 2'd1;
                    cnt_d = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
    end

    assign a         = vec_q[1];
    assign b         = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_cnt_q;
    assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gates_sweep_checker.sv
// Scoreboard bench for gates_sweep_checker: a gate-bank model with injectable faults feeds y_in.
module tb_gates_sweep_checker;

    typedef struct {
        int done_cyc;
        int cnt;
        int mask;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] y_in;
    logic       a, b, busy, done, pass;
    logic [1:0] vec_idx;
    logic [2:0] err_count;
    logic [6:0] err_mask;

    logic       start1 = 1'b0;
    logic [6:0] y1;
    logic       a1, b1, busy1, done1, pass1;
    logic [1:0] vec_idx1;
    logic [2:0] err_count1;
    logic [6:0] err_mask1;

    logic       ovr_en = 1'b0;
    logic [6:0] ovr = '0, clr = '0, set = '0;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic done_prev = 1'b0;

    function automatic logic [6:0] gate_truth(input logic av, input logic bv);
        return {~av, ~(av ^ bv), av ^ bv, ~(av | bv), ~(av & bv), av | bv, av & bv};
    endfunction

    assign y_in = ovr_en ? ovr : ((gate_truth(a, b) & ~clr) | set);
    assign y1   = gate_truth(a1, b1);

    gates_sweep_checker #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
        .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .err_mask(err_mask)
    );

    gates_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .a(a1), .b(b1), .vec_idx(vec_idx1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err_count1), .err_mask(err_mask1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, 32'(a), 0);
        chk({tag, "_b"}, 32'(b), 0);
        chk({tag, "_vec"}, 32'(vec_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_errcnt"}, 32'(err_count), 0);
        chk({tag, "_errmask"}, 32'(err_mask), 0);
    endtask

    // Monitor: every rising edge of done consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.done_cyc));
                chk("pass", 32'(pass), 32'(e.pass));
                chk("err_count", 32'(err_count), 32'(e.cnt));
                chk("err_mask", 32'(err_mask), 32'(e.mask));
                chk("busy_at_done", 32'(busy), 0);
                chk("ab_at_done", 32'({a, b}), 32'h3);
                chk("vec_at_done", 32'(vec_idx), 3);
            end
        end
        done_prev = done;
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, 1, 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Issue a start pulse and queue the hand-computed result.
    task automatic run_sweep(input string name, input int cnt, input int mask, input int p);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_accept_busy"}, 32'(busy), 1);
        e.done_cyc = cyc + 20;
        e.cnt = cnt;
        e.mask = mask;
        e.pass = p;
        sb.push_back(e);
        wait_drain(name);
    endtask

    initial begin
        exp_t e;
        int   acc;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1: correct bank
        run_sweep("t1", 0, 'h00, 1);

        // T2: XOR stuck at 0, then restart by holding start in DONE with the fault removed
        clr = 7'h10;
        run_sweep("t2", 2, 'h10, 0);
        clr = 7'h00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_done_drop", 32'(done), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_errcnt_clr", 32'(err_count), 0);
        chk("restart_errmask_clr", 32'(err_mask), 0);
        chk("restart_vec", 32'(vec_idx), 0);
        start = 1'b0;
        e.done_cyc = cyc + 20; e.cnt = 0; e.mask = 'h00; e.pass = 1;
        sb.push_back(e);
        wait_drain("t5_restart");

        // T3: bank outputs all zero
        ovr_en = 1'b1;
        ovr = 7'h00;
        run_sweep("t3", 4, 'h7F, 0);
        ovr_en = 1'b0;

        // NOT output stuck at 1: wrong only when a=1
        set = 7'h40;
        run_sweep("not_stuck1", 2, 'h40, 0);
        set = 7'h00;

        // T5: start re-pulsed while busy has no effect on timing
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e.done_cyc = cyc + 20; e.cnt = 0; e.mask = 'h00; e.pass = 1;
        sb.push_back(e);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_vec", 32'(vec_idx), 1);
        wait_drain("t5_busy");

        // T4: async reset during SETTLE of vector 2
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("t4_vec2", 32'(vec_idx), 2);
        chk("t4_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t4_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("t4_no_result", 32'(done), 0);
        run_sweep("t4_fresh", 0, 'h00, 1);

        // T6: SETTLE_CYCLES=1 instance
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        acc = cyc;
        for (int i = 0; i < 8; i++) begin
            chk("t6_ab", 32'({a1, b1}), 32'(i / 2));
            chk("t6_not_done", 32'(done1), 0);
            @(negedge clk);
        end
        chk("t6_latency", 32'(cyc - acc), 8);
        chk("t6_done", 32'(done1), 1);
        chk("t6_pass", 32'(pass1), 1);
        chk("t6_errcnt", 32'(err_count1), 0);
        chk("t6_errmask", 32'(err_mask1), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
